tx_frame_arbiter: RTL and testbench
===================================

TX_FRAME_ARBITER -- requirements
Module: tx_frame_arbiter

Interface
REQ-001 SHALL have parameter P_DATA_W, 8, byte width of data bus.
REQ-002 SHALL have parameter P_IFG_CYCLES, 2, idle cycles inserted after each frame (used only when SW_ARB_IFG_EN is defined); legal range 1..15.
REQ-003 SHALL have ports (name  direction  width  meaning), with the clock and reset listed first:
- clk_i  in  1  single clock
- rstn_i  in  1  asynchronous active-low reset
- req_i  in  3  requester r has at least one complete frame queued (level)
- rd_data_i  in  3xP_DATA_W  head byte of requester r queue (first-word-fall-through)
- rd_last_i  in  3  head byte of requester r is the frame's last byte
- rd_en_o  out  3  pop strobe to requester r
- grant_o  out  3  one-hot current owner of the TX port
- tx_data_o  out  P_DATA_W  registered TX byte
- tx_ctrl_o  out  1  tx_data_o valid
- busy_o  out  1  state is not IDLE

Function
REQ-004 SHALL implement states IDLE, XFER and GAP; GAP exists only with SW_ARB_IFG_EN.
REQ-005 IDLE: if req_i != 0, SHALL pick a winner round-robin, register it in grant_o, and enter XFER next cycle; if req_i == 0, SHALL stay in IDLE.
REQ-006 Round-robin SHALL rank requesters (ptr+1, ptr+2, ptr) mod 3, where ptr is the last winner; ptr SHALL update only on a grant.
REQ-007 XFER: SHALL assert rd_en_o[g] = grant_o[g] every cycle; all other rd_en_o bits SHALL be 0.
REQ-008 XFER: SHALL register tx_data_o <= rd_data_i[g] and tx_ctrl_o <= 1 each cycle, giving 1-cycle latency from pop to tx_ctrl_o.
REQ-009 XFER with rd_last_i[g]=1: SHALL pop that byte, then go to GAP (macro defined) or IDLE (macro undefined); grant_o SHALL clear the same cycle.
REQ-010 Once granted, the grant SHALL be held until the last byte; deassertion of req_i[g] or requests from others mid-frame SHALL be ignored.
REQ-011 Latency: req_i rising in IDLE at cycle n SHALL give grant_o and rd_en_o at n+1 and first tx_ctrl_o at n+2.
REQ-012 Single-byte frame (rd_last_i set on the first pop) SHALL produce exactly one tx_ctrl_o cycle.
REQ-013 At least one cycle with tx_ctrl_o=0 SHALL separate consecutive frames.
REQ-014 grant_o SHALL always be one-hot or zero; tx_data_o SHALL hold its value when tx_ctrl_o=0.
REQ-015 busy_o SHALL be combinational from the state.

Reset
REQ-016 On rstn_i low, outputs SHALL go to 0 asynchronously, state to IDLE, ptr to 2 (requester 0 first), and the IFG counter to 0.
REQ-017 Reset during XFER SHALL abandon the frame: no further pops, and the frame SHALL NOT be resumed after release.

Configuration
REQ-018 With SW_ARB_IFG_EN defined: the GAP state SHALL count P_IFG_CYCLES cycles with all outputs 0 except busy_o=1, then go to IDLE.
REQ-019 Without SW_ARB_IFG_EN: GAP and its counter SHALL be absent, and XFER SHALL return directly to IDLE.

Structure
REQ-020 Shared package sw_pkg SHALL hold the arb_state_e enum, N_REQ=3 and the default data width.
REQ-021 A combinational sub-module rr_picker (req, ptr -> one-hot winner) SHALL be instantiated once.

Verification
REQ-022 Single requester: req_i=3'b001 with a 4-byte frame AA..AD -> grant_o=001 at n+1, tx_data_o AA,AB,AC,AD with tx_ctrl_o at n+2..n+5, then IDLE.
REQ-023 All requesting after reset: req_i=3'b111 with 8-byte frames -> grant order 0,1,2,0, no interleaved bytes.
REQ-024 Mid-frame release: requester 1 drops req_i during its frame -> grant held until rd_last_i, all bytes emitted.
REQ-025 One-byte frames back-to-back from requester 2 -> tx_ctrl_o pulses separated by 1 idle cycle (macro off) or P_IFG_CYCLES+1 (macro on, default 3).
REQ-026 Reset at byte 3 of a 10-byte frame -> all outputs 0 immediately; after release with req_i=3'b011, requester 0 is granted.
REQ-027 Random requests over 1000 frames -> scoreboard per requester, grant_o one-hot assertion, zero mismatches.

Source files
------------

// File: rtl/sw_pkg.sv
// Shared definitions for the TX frame arbiter: requester count, default
// data width, arbiter state encoding and a one-hot to index helper.
// The GAP state exists only when SW_ARB_IFG_EN is defined.
package sw_pkg;

    localparam int N_REQ      = 3;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1
`ifdef SW_ARB_IFG_EN
        ,
        ST_GAP  = 2'd2
`endif
    } arb_state_e;

    // Index of the set bit of a one-hot requester vector (0 when none is set).
    function automatic logic [1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: ranks requesters (ptr+1, ptr+2, ptr)
// mod N_REQ and returns the one-hot winner, or zero when nobody requests.
module rr_picker
    import sw_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  logic [1:0]       ptr_i,
    output logic [N_REQ-1:0] win_o
);

    // Scan from lowest to highest priority so the highest-priority requester wins.
    always_comb begin
        int cand;
        // NOTE: every combinationally assigned signal gets a default first, so no latch is inferred.
        win_o = '0;
        cand  = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = (int'(ptr_i) + k) % N_REQ;
            if (req_i[cand]) begin
                win_o       = '0;
                win_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_frame_arbiter.sv
// Three-requester TX frame arbiter. A round-robin winner owns the TX port
// for a whole frame; bytes are popped from its FWFT queue and registered
// onto tx_data_o/tx_ctrl_o one cycle later.
// Optional feature macro: SW_ARB_IFG_EN adds a GAP state of P_IFG_CYCLES
// idle cycles after each frame; without it XFER returns straight to IDLE.
module tx_frame_arbiter
    import sw_pkg::*;
#(
    parameter int P_DATA_W     = DATA_W_DEF,
    parameter int P_IFG_CYCLES = 2
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic [N_REQ-1:0]          req_i,
    input  logic [N_REQ*P_DATA_W-1:0] rd_data_i,
    input  logic [N_REQ-1:0]          rd_last_i,
    output logic [N_REQ-1:0]          rd_en_o,
    output logic [N_REQ-1:0]          grant_o,
    output logic [P_DATA_W-1:0]       tx_data_o,
    output logic                      tx_ctrl_o,
    output logic                      busy_o
);

    if (P_IFG_CYCLES < 1 || P_IFG_CYCLES > 15) begin : g_ifg_range_check
        $error("tx_frame_arbiter: P_IFG_CYCLES must be in 1..15");
    end

    arb_state_e           state_q;
    logic [N_REQ-1:0]     grant_q;
    logic [1:0]           ptr_q;
    logic [P_DATA_W-1:0]  tx_data_q;
    logic                 tx_ctrl_q;
    logic [N_REQ-1:0]     win;
    logic [P_DATA_W-1:0]  sel_data;
    logic                 sel_last;
`ifdef SW_ARB_IFG_EN
    logic [3:0]           ifg_cnt_q;
`endif

    rr_picker u_rr_picker (
        .req_i (req_i),
        .ptr_i (ptr_q),
        .win_o (win)
    );

    // Head byte and last flag of the current owner's queue.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q[i]) sel_data = rd_data_i[i*P_DATA_W +: P_DATA_W];
        end
        sel_last = |(rd_last_i & grant_q);
    end

    // Arbiter FSM with registered grant and TX outputs.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            ptr_q     <= 2'd2;
            tx_data_q <= '0;
            tx_ctrl_q <= 1'b0;
`ifdef SW_ARB_IFG_EN
            ifg_cnt_q <= '0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            tx_ctrl_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (|req_i) begin
                        grant_q <= win;
                        ptr_q   <= onehot_to_idx(win);
                        state_q <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    tx_data_q <= sel_data;
                    tx_ctrl_q <= 1'b1;
                    if (sel_last) begin
                        grant_q <= '0;
`ifdef SW_ARB_IFG_EN
                        ifg_cnt_q <= '0;
                        state_q   <= ST_GAP;
`else
                        state_q   <= ST_IDLE;
`endif
                    end
                end
`ifdef SW_ARB_IFG_EN
                ST_GAP: begin
                    if (ifg_cnt_q == 4'(P_IFG_CYCLES - 1)) begin
                        ifg_cnt_q <= '0;
                        state_q   <= ST_IDLE;
                    end else begin
                        ifg_cnt_q <= ifg_cnt_q + 4'd1;
                    end
                end
`endif
                default: begin
                    grant_q <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // The grant register is non-zero only in XFER, so it doubles as the pop strobe.
    assign rd_en_o   = grant_q;
    assign grant_o   = grant_q;
    assign tx_data_o = tx_data_q;
    assign tx_ctrl_o = tx_ctrl_q;
    assign busy_o    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Self-checking bench for tx_frame_arbiter. A transaction-level model keeps
// per-requester frame queues, a round-robin pointer and the cycle at which
// the arbiter is free again, and predicts grant, pops and TX bytes per cycle.
`timescale 1ns/1ps
module tb_tx_frame_arbiter;

    localparam int NR  = 3;
    localparam int DW  = 8;
    localparam int IFG = 2;
`ifdef SW_ARB_IFG_EN
    localparam int GAP = IFG;
`else
    localparam int GAP = 0;
`endif

    typedef struct packed {
        logic [DW-1:0] d;
        logic          last;
    } ent_t;

    logic             clk_i = 1'b0;
    logic             rstn_i = 1'b1;
    logic [NR-1:0]    req_i = '0;
    logic [NR*DW-1:0] rd_data_i = '0;
    logic [NR-1:0]    rd_last_i = '0;
    logic [NR-1:0]    rd_en_o;
    logic [NR-1:0]    grant_o;
    logic [DW-1:0]    tx_data_o;
    logic             tx_ctrl_o;
    logic             busy_o;

    always #5 clk_i = ~clk_i;

    tx_frame_arbiter #(.P_DATA_W(DW), .P_IFG_CYCLES(IFG)) dut (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .req_i     (req_i),
        .rd_data_i (rd_data_i),
        .rd_last_i (rd_last_i),
        .rd_en_o   (rd_en_o),
        .grant_o   (grant_o),
        .tx_data_o (tx_data_o),
        .tx_ctrl_o (tx_ctrl_o),
        .busy_o    (busy_o)
    );

    // Source FIFOs seen by the DUT and expected streams used by the model.
    ent_t src_q[NR][$];
    ent_t exp_q[NR][$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Model state.
    int            owner       = -1;
    int            mptr        = 2;
    int            ready_cyc   = 0;
    logic [NR-1:0] cur_req     = '0;
    logic          pend_valid  = 1'b0;
    logic [DW-1:0] pend_data   = '0;
    logic [DW-1:0] last_data   = '0;
    int            frames_done = 0;
    logic [NR-1:0] req_mask    = '1;

    // Observation logs for directed checks.
    int            tx_cyc_q[$];
    logic [DW-1:0] tx_dat_q[$];
    int            gnt_cyc_q[$];
    int            gnt_idx_q[$];
    logic [NR-1:0] obs_prev_gnt = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input logic [NR-1:0] req, input int ptr);
        for (int k = 1; k <= NR; k++) begin
            int c;
            c = (ptr + k) % NR;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    task automatic drive_inputs();
        for (int r = 0; r < NR; r++) begin
            if (src_q[r].size() > 0) begin
                rd_data_i[r*DW +: DW] = src_q[r][0].d;
                rd_last_i[r]          = src_q[r][0].last;
                req_i[r]              = req_mask[r];
            end else begin
                rd_data_i[r*DW +: DW] = '0;
                rd_last_i[r]          = 1'b0;
                req_i[r]              = 1'b0;
            end
        end
    endtask

    task automatic push_frame(input int r, input int len, input logic [DW-1:0] base);
        ent_t e;
        for (int i = 0; i < len; i++) begin
            e.d    = base + DW'(i);
            e.last = (i == len - 1);
            src_q[r].push_back(e);
            exp_q[r].push_back(e);
        end
        drive_inputs();
    endtask

    // One clock cycle: check outputs mid-cycle, advance the model, then
    // apply the DUT's pops to the sources after the edge.
    task automatic step();
        logic [NR-1:0] eg;
        logic [NR-1:0] pops;
        ent_t          e;
        @(negedge clk_i);
        cyc++;
        if (owner < 0 && (cyc - 1) >= ready_cyc && cur_req != '0) begin
            owner = rr_pick(cur_req, mptr);
            mptr  = owner;
        end
        eg = (owner >= 0) ? NR'(1 << owner) : '0;
        check("grant", grant_o, eg);
        check("rd_en", rd_en_o, eg);
        check("tx_ctrl", tx_ctrl_o, pend_valid);
        check("tx_data", tx_data_o, pend_valid ? pend_data : last_data);
        check("busy", busy_o, (eg != '0) || (cyc < ready_cyc));

        if (tx_ctrl_o === 1'b1) begin
            tx_cyc_q.push_back(cyc);
            tx_dat_q.push_back(tx_data_o);
        end
        if (grant_o != '0 && obs_prev_gnt == '0) begin
            gnt_cyc_q.push_back(cyc);
            for (int r = 0; r < NR; r++) if (grant_o[r]) gnt_idx_q.push_back(r);
        end
        obs_prev_gnt = grant_o;

        if (pend_valid) last_data = pend_data;
        pend_valid = 1'b0;
        if (owner >= 0) begin
            if (exp_q[owner].size() == 0) begin
                check("model_underrun", 1, 0);
                owner = -1;
            end else begin
                e          = exp_q[owner].pop_front();
                pend_valid = 1'b1;
                pend_data  = e.d;
                if (e.last) begin
                    owner     = -1;
                    ready_cyc = cyc + 1 + GAP;
                    frames_done++;
                end
            end
        end
        pops = rd_en_o;

        @(posedge clk_i);
        #1;
        cur_req = req_i;
        for (int r = 0; r < NR; r++) begin
            if (pops[r] === 1'b1 && src_q[r].size() > 0) void'(src_q[r].pop_front());
        end
        drive_inputs();
    endtask

    task automatic do_reset(input int hold);
        rstn_i = 1'b0;
        #1;
        check("rst_grant", grant_o, 0);
        check("rst_rd_en", rd_en_o, 0);
        check("rst_tx_ctrl", tx_ctrl_o, 0);
        check("rst_tx_data", tx_data_o, 0);
        check("rst_busy", busy_o, 0);
        for (int r = 0; r < NR; r++) begin
            src_q[r].delete();
            exp_q[r].delete();
        end
        owner      = -1;
        mptr       = 2;
        pend_valid = 1'b0;
        last_data  = '0;
        req_mask   = '1;
        drive_inputs();
        repeat (hold) @(posedge clk_i);
        #1;
        rstn_i       = 1'b1;
        cur_req      = '0;
        ready_cyc    = cyc + 1;
        obs_prev_gnt = '0;
        tx_cyc_q.delete();
        tx_dat_q.delete();
        gnt_cyc_q.delete();
        gnt_idx_q.delete();
    endtask

    function automatic logic model_idle();
        logic empty;
        empty = 1'b1;
        for (int r = 0; r < NR; r++) if (exp_q[r].size() != 0) empty = 1'b0;
        return empty && owner < 0 && !pend_valid && cyc >= ready_cyc;
    endfunction

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while (!model_idle() && n < budget) begin
            step();
            n++;
        end
        if (!model_idle()) check("idle_timeout", 1, 0);
        step();
    endtask

    initial begin
        int n;
        logic [DW-1:0] exp_b;

        do_reset(3);

        // Single requester, 4-byte frame AA..AD.
        push_frame(0, 4, 8'hAA);
        n = cyc + 1;
        run_until_idle(50);
        check("r22_ntx", tx_cyc_q.size(), 4);
        if (tx_cyc_q.size() == 4 && gnt_cyc_q.size() > 0) begin
            check("r22_gnt_cyc", gnt_cyc_q[0], n + 1);
            check("r22_first_tx", tx_cyc_q[0], n + 2);
            check("r22_last_tx", tx_cyc_q[3], n + 5);
            for (int i = 0; i < 4; i++) begin
                exp_b = 8'hAA + DW'(i);
                check("r22_byte", tx_dat_q[i], exp_b);
            end
        end

        // All requesting after reset: grant order 0,1,2,0.
        do_reset(2);
        push_frame(0, 8, 8'h10);
        push_frame(1, 8, 8'h20);
        push_frame(2, 8, 8'h30);
        push_frame(0, 8, 8'h40);
        run_until_idle(200);
        check("r23_ngrants", gnt_idx_q.size(), 4);
        if (gnt_idx_q.size() == 4) begin
            check("r23_order0", gnt_idx_q[0], 0);
            check("r23_order1", gnt_idx_q[1], 1);
            check("r23_order2", gnt_idx_q[2], 2);
            check("r23_order3", gnt_idx_q[3], 0);
        end
        check("r23_ntx", tx_cyc_q.size(), 32);

        // Mid-frame release by requester 1.
        do_reset(2);
        push_frame(1, 6, 8'h50);
        n = 0;
        while (owner != 1 && n < 20) begin
            step();
            n++;
        end
        check("r24_granted", owner, 1);
        step();
        req_mask[1] = 1'b0;
        drive_inputs();
        run_until_idle(50);
        req_mask = '1;
        drive_inputs();
        check("r24_ntx", tx_cyc_q.size(), 6);

        // Back-to-back single-byte frames from requester 2.
        do_reset(2);
        push_frame(2, 1, 8'h61);
        push_frame(2, 1, 8'h62);
        push_frame(2, 1, 8'h63);
        run_until_idle(60);
        check("r25_ntx", tx_cyc_q.size(), 3);
        if (tx_cyc_q.size() == 3) begin
            check("r25_space0", tx_cyc_q[1] - tx_cyc_q[0], 2 + GAP);
            check("r25_space1", tx_cyc_q[2] - tx_cyc_q[1], 2 + GAP);
        end

        // Reset during byte 3 of a 10-byte frame, then requesters 0 and 1.
        do_reset(2);
        push_frame(1, 3, 8'h70);
        run_until_idle(40);
        push_frame(0, 10, 8'h80);
        tx_cyc_q.delete();
        n = 0;
        while (tx_cyc_q.size() < 3 && n < 40) begin
            step();
            n++;
        end
        check("r26_reached_b3", tx_cyc_q.size(), 3);
        do_reset(2);
        push_frame(0, 2, 8'h90);
        push_frame(1, 2, 8'hA0);
        run_until_idle(40);
        check("r26_ngrants", gnt_idx_q.size(), 2);
        if (gnt_idx_q.size() > 0) check("r26_first_owner", gnt_idx_q[0], 0);

        // Random traffic: 1000 frames with mid-frame request drops.
        do_reset(2);
        frames_done = 0;
        n = 0;
        while (frames_done < 1000 && n < 20000) begin
            int r;
            if ($urandom_range(2) == 0) begin
                r = $urandom_range(NR - 1);
                if (src_q[r].size() < 20)
                    push_frame(r, $urandom_range(6, 1), DW'($urandom));
            end
            req_mask = '1;
            if (owner >= 0 && $urandom_range(3) == 0) req_mask[owner] = 1'b0;
            drive_inputs();
            step();
            n++;
        end
        req_mask = '1;
        drive_inputs();
        run_until_idle(400);
        check("rand_frames", frames_done >= 1000, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #800_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
